uart_tx_fifo: RTL and testbench

UART transmitter for the robot command link, 8N1, LSB first, idle-high line. Bytes are pushed into a small internal FIFO and serialized back-to-back on TX. It is the transmit end matching the team's UART receiver: same bit period and frame format, so TX can be looped directly into the receiver's RX.

---
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter for the robot command link: 8N1, LSB first, idle-high.
// Bytes are queued in a small FIFO and sent back-to-back with no idle gap
// between frames, so TX can drive the matching UART receiver directly.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 2604,  // clk cycles per bit, 16..4095
  parameter int FIFO_DEPTH = 4      // power of two, 2..16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       TX
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [11:0]       BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0]       BAUD_PRE  = 12'(BAUD_DIV - 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  // One-hot encodings leave illegal codes that must fall back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_SEND = 2'b10
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, overflow_q;

  // Transmitter state
  state_e           state_q;
  logic [9:0]       shift_q;
  logic [11:0]      baud_q;
  logic [3:0]       bit_cnt_q;
  logic             busy_q, done_q;

  logic push, pop, bit_end, frame_end, done_next;

  assign push      = wr_en && !full_q;
  assign bit_end   = busy_q && (baud_q == BAUD_LAST);
  assign frame_end = bit_end && (bit_cnt_q == 4'd9);
  // A pop happens only when the shifter is free: idle, or finishing a stop bit.
  assign pop       = !empty_q && ((state_q == S_IDLE) ||
                                  ((state_q == S_SEND) && frame_end));
  // Decoded one cycle early so the registered tx_done lands in the last
  // cycle of the stop bit.
  assign done_next = (state_q == S_SEND) && busy_q &&
                     (bit_cnt_q == 4'd9) && (baud_q == BAUD_PRE);

  // Next FIFO occupancy from this cycle's push/pop pair
  always_comb begin
    // NOTE: assign a default first so every path drives count_d; otherwise
    // the missing case arms would infer a latch.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array write port
  // NOTE: the storage array has no reset; entries are only read after a
  // push has written them, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, count and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == '0);
      overflow_q <= wr_en && full_q;
    end
  end

  // Frame FSM: load, shift at each bit boundary, reload back-to-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '1;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_next;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q   <= {1'b1, mem_q[rd_ptr_q], 1'b0};
            baud_q    <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_cnt_q == 4'd9) begin
              bit_cnt_q <= '0;
              if (pop) begin
                shift_q <= {1'b1, mem_q[rd_ptr_q], 1'b0};
              end else begin
                shift_q <= '1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              shift_q   <= {1'b1, shift_q[9:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + 12'd1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          shift_q   <= '1;
          baud_q    <= '0;
          bit_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign TX       = shift_q[0];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one slow instance at the field bit rate
// for exact frame timing, one fast instance for FIFO, ordering, reset and
// receiver-loopback scenarios.
module tb_uart_tx_fifo;

  localparam int BD    = 16;
  localparam int FRAME = 10 * BD;
  localparam int SBD   = 2604;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       wr_en, full, empty, overflow, tx_busy, tx_done, TX;
  logic [7:0] wr_data;

  logic       s_wr_en, s_full, s_empty, s_overflow, s_tx_busy, s_tx_done, s_TX;
  logic [7:0] s_wr_data;

  int tests = 0;
  int fails = 0;

  bit         log_en = 1'b0;
  bit         tx_log[$];
  bit         done_log[$];
  bit         busy_log[$];
  int         ovf_cnt = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow),
    .tx_busy(tx_busy), .tx_done(tx_done), .TX(TX)
  );

  uart_tx_fifo #(.BAUD_DIV(SBD), .FIFO_DEPTH(4)) dut_slow (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .full(s_full), .empty(s_empty), .overflow(s_overflow),
    .tx_busy(s_tx_busy), .tx_done(s_tx_done), .TX(s_TX)
  );

  always #5 clk = ~clk;

  // Trace of the fast instance, sampled on the falling edge
  always @(negedge clk) begin
    if (log_en) begin
      tx_log.push_back(TX);
      done_log.push_back(tx_done);
      busy_log.push_back(tx_busy);
      if (overflow) ovf_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    tx_log.delete();
    done_log.delete();
    busy_log.delete();
    ovf_cnt = 0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Compare the logged trace against back-to-back frames of exp_q
  task automatic check_stream(input string tag);
    int f, n, bad, busy_bad, done_bad, idle_bad, ndone, pos, b;
    n = exp_q.size();
    f = -1;
    bad = 0; busy_bad = 0; done_bad = 0; idle_bad = 0; ndone = 0;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] == 1'b0) begin
        f = i;
        break;
      end
    end
    check({tag, " start_found"}, f >= 0, 1);
    check({tag, " log_long_enough"}, (f + n * FRAME) < tx_log.size(), 1);
    for (int i = 0; i < done_log.size(); i++) if (done_log[i]) ndone++;
    if (f >= 0 && (f + n * FRAME) < tx_log.size()) begin
      for (int k = 0; k < n * FRAME; k++) begin
        pos = k % FRAME;
        b   = pos / BD;
        if (tx_log[f+k] !== frame_bit(exp_q[k / FRAME], b)) bad++;
        if (busy_log[f+k] !== 1'b1) busy_bad++;
        if (done_log[f+k] !== (pos == FRAME - 1)) done_bad++;
      end
      for (int i = f + n * FRAME; i < tx_log.size(); i++)
        if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) idle_bad++;
    end
    check({tag, " bit_errors"}, bad, 0);
    check({tag, " busy_gaps"}, busy_bad, 0);
    check({tag, " done_timing_errors"}, done_bad, 0);
    check({tag, " done_count"}, ndone, n);
    check({tag, " idle_after"}, idle_bad, 0);
  endtask

  // Mid-bit sampling receiver model standing in for the team's UART RX
  task automatic rx_model(output logic [7:0] cmd, output logic rdy);
    int w;
    logic start_ok;
    w = 0;
    cmd = '0;
    rdy = 1'b0;
    while (TX === 1'b1 && w < 50) begin
      tick(1);
      w++;
    end
    if (TX === 1'b0) begin
      tick(BD / 2);
      start_ok = (TX === 1'b0);
      for (int i = 0; i < 8; i++) begin
        tick(BD);
        cmd[i] = TX;
      end
      tick(BD);
      rdy = start_ok && (TX === 1'b1);
      tick(BD);
    end
  endtask

  initial begin
    logic [9:0] a5_bits;
    logic [7:0] got;
    logic       rdy;
    logic [7:0] lb_bytes [3];
    int mism, done_cnt, first_done, empty_bad, w, q_bad;
    logic busy_last, busy_after;

    rst_n = 1'b0;
    wr_en = 1'b0; wr_data = '0;
    s_wr_en = 1'b0; s_wr_data = '0;

    // Reset state
    tick(3);
    check("rst TX", TX, 1);
    check("rst tx_busy", tx_busy, 0);
    check("rst tx_done", tx_done, 0);
    check("rst overflow", overflow, 0);
    check("rst full", full, 0);
    check("rst empty", empty, 1);
    check("rst slow TX", s_TX, 1);
    check("rst slow empty", s_empty, 1);
    rst_n = 1'b1;
    tick(2);

    // Single 0xA5 frame at the field bit rate
    a5_bits = 10'b1101001010;
    s_wr_en = 1'b1; s_wr_data = 8'hA5;
    tick(1);
    s_wr_en = 1'b0;
    check("a5 TX high at N+1", s_TX, 1);
    tick(1);
    check("a5 TX low at N+2", s_TX, 0);
    mism = 0; done_cnt = 0; first_done = -1; empty_bad = 0;
    busy_last = 1'b0; busy_after = 1'b1;
    for (int k = 0; k < 26046; k++) begin
      if (s_TX !== ((k < 10 * SBD) ? a5_bits[k / SBD] : 1'b1)) mism++;
      if (s_tx_done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (s_empty !== 1'b1) empty_bad++;
      if (k == 10 * SBD - 1) busy_last = s_tx_busy;
      if (k == 10 * SBD) busy_after = s_tx_busy;
      tick(1);
    end
    check("a5 bit errors", mism, 0);
    check("a5 done count", done_cnt, 1);
    check("a5 done offset", first_done, 10 * SBD - 1);
    check("a5 empty held", empty_bad, 0);
    check("a5 busy in done cycle", busy_last, 1);
    check("a5 busy after frame", busy_after, 0);

    // Three consecutive pushes -> back-to-back frames
    clear_log();
    log_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick(1);
    end
    wr_en = 1'b0;
    tick(3 * FRAME + 40);
    log_en = 1'b0;
    exp_q = '{8'h01, 8'h02, 8'h03};
    check_stream("b2b");

    // Six pushes into a depth-4 FIFO: one dropped with an overflow pulse
    clear_log();
    log_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("fill full before 6th push", full, 1);
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick(1);
    end
    wr_en = 1'b0;
    check("fill overflow pulse", overflow, 1);
    tick(1);
    check("fill overflow single", overflow, 0);
    tick(5 * FRAME + 40);
    log_en = 1'b0;
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_stream("fill");
    check("fill overflow count", ovf_cnt, 1);

    // Push rejected while full, in the same cycle as the tx_done pop
    clear_log();
    log_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
      tick(1);
    end
    wr_en = 1'b0;
    tick(1);
    check("popfull full", full, 1);
    w = 0;
    while (tx_done !== 1'b1 && w < 400) begin
      tick(1);
      w++;
    end
    check("popfull done seen", tx_done, 1);
    check("popfull full at done", full, 1);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick(1);
    wr_en = 1'b0;
    check("popfull overflow", overflow, 1);
    check("popfull full dropped", full, 0);
    check("popfull not empty", empty, 0);
    check("popfull busy", tx_busy, 1);
    tick(4 * FRAME + 40);
    log_en = 1'b0;
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    check_stream("popfull");
    check("popfull overflow count", ovf_cnt, 1);

    // Reset in bit 4 of 0x3C abandons the frame
    wr_en = 1'b1; wr_data = 8'h3C;
    tick(1);
    wr_en = 1'b0;
    w = 0;
    while (TX !== 1'b0 && w < 20) begin
      tick(1);
      w++;
    end
    check("rstmid start bit", TX, 0);
    tick(4 * BD + 8);
    rst_n = 1'b0;
    #1;
    check("rstmid TX", TX, 1);
    check("rstmid busy", tx_busy, 0);
    check("rstmid empty", empty, 1);
    check("rstmid done", tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q_bad = 0;
    repeat (300) begin
      tick(1);
      if (tx_done !== 1'b0 || TX !== 1'b1 || tx_busy !== 1'b0) q_bad++;
    end
    check("rstmid quiet after", q_bad, 0);
    clear_log();
    log_en = 1'b1;
    wr_en = 1'b1; wr_data = 8'h55;
    tick(1);
    wr_en = 1'b0;
    tick(FRAME + 40);
    log_en = 1'b0;
    exp_q = '{8'h55};
    check_stream("rstmid 55");

    // Loopback into a receiver model
    lb_bytes = '{8'h5A, 8'h00, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = lb_bytes[i];
      tick(1);
      wr_en = 1'b0;
      rx_model(got, rdy);
      check("loop rdy", rdy, 1);
      check("loop cmd", got, lb_bytes[i]);
      tick(4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
